hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, the single pipeline clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-003 The block SHALL have port id_valid, input, 1, meaning the IF/ID register holds a real instruction.
REQ-004 The block SHALL have ports id_opcode (input, 7, ID opcode) and id_funct (input, 4, ID funct12[3:0]).
REQ-005 The block SHALL have ports id_rs1 and id_rs2 (input, 5 each, ID source registers) and id_use_rs1 and id_use_rs2 (input, 1 each, set when that source is actually read).
REQ-006 The block SHALL have ports ex_rd (input, 5), ex_reg_write (input, 1, RegWrite!=0) and ex_mem_read (input, 1), describing the ID/EX register contents.
REQ-007 The block SHALL have ports mem_rd (input, 5) and mem_reg_write (input, 1), describing the EX/MEM register contents.
REQ-008 The block SHALL have ports ex_branch_taken and ex_jump (input, 1 each): a branch resolved taken, or jal/jalr, in EX.
REQ-009 The block SHALL have port stall, output, 1: hold the PC and IF/ID.
REQ-010 The block SHALL have port idex_bubble, output, 1: load a NOP (all controls 0) into ID/EX.
REQ-011 The block SHALL have port flush_ifid, output, 1: load a NOP into IF/ID.
REQ-012 The block SHALL have port ex_hold, output, 1: hold ID/EX and insert a bubble into EX/MEM.
REQ-013 The block SHALL have ports fwd_a and fwd_b (output, 2 each, registered EX operand selects): 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused.

Function
REQ-014 A multiply class instruction SHALL be defined as opcode 0000001 with id_funct 0010 (MUL) or 1001 (MA), or opcode 0000100 (MULI).
REQ-015 The FSM SHALL have exactly two states, RUN and MULWAIT, plus a 2-bit down-counter mul_cnt.
REQ-016 load_use SHALL be true when id_valid, ex_mem_read and ex_rd!=0 are all true, and (id_use_rs1 with id_rs1==ex_rd) or (id_use_rs2 with id_rs2==ex_rd).
REQ-017 redirect SHALL equal ex_branch_taken OR ex_jump.
REQ-018 In RUN with redirect true, the block SHALL assert flush_ifid=1, idex_bubble=1 and stall=0 in the same cycle, so the PC takes the target; redirect has priority over load_use.
REQ-019 In RUN with load_use true and redirect false, the block SHALL assert stall=1 and idex_bubble=1 for that cycle only; the stall clears the following cycle because ex_mem_read is then 0.
REQ-020 In RUN, when a multiply class instruction transfers from ID to EX (id_valid=1, no stall, no bubble, no flush), the block SHALL set mul_cnt=2 and move to MULWAIT at the next edge.
REQ-021 In MULWAIT, the block SHALL assert stall=1 and ex_hold=1 with idex_bubble=0 and flush_ifid=0, and decrement mul_cnt each cycle.
REQ-022 When mul_cnt==1 in MULWAIT, the next edge SHALL return to RUN; the multiply therefore occupies EX for 3 cycles total.
REQ-023 In MULWAIT, redirect and load_use SHALL be ignored, since a multiply in EX cannot be a branch or load.
REQ-024 On every ID-to-EX transfer, the block SHALL register fwd_a: 01 if id_rs1==ex_rd, ex_reg_write=1 and ex_rd!=0; else 10 if id_rs1==mem_rd, mem_reg_write=1 and mem_rd!=0; else 00.
REQ-025 fwd_b SHALL be computed the same way as fwd_a, using id_rs2.
REQ-026 When idex_bubble is asserted, fwd_a and fwd_b SHALL load 00.
REQ-027 While stall or ex_hold is asserted without a bubble, fwd_a and fwd_b SHALL hold their values.
REQ-028 Source register x0 SHALL never forward.
REQ-029 In RUN with no hazard, all outputs other than fwd_a and fwd_b SHALL be 0.

Reset
REQ-030 While rst_n=0, regardless of the clock, the block SHALL force state RUN, mul_cnt=0 and fwd_a=fwd_b=00.
REQ-031 While rst_n=0, stall, idex_bubble, flush_ifid and ex_hold SHALL all be 0.
REQ-032 Reset asserted during MULWAIT SHALL abort the wait; after release, the block SHALL start in RUN.

Verification
REQ-033 The bench SHALL cover load-use: EX holds a load with ex_rd=5, ID is ADD using rs1=5 -> stall=1 and idex_bubble=1 for 1 cycle, then fwd_a=10 on the ADD's entry to EX.
REQ-034 The bench SHALL cover simultaneous events: ex_branch_taken=1 in the same cycle as load_use -> flush_ifid=1, idex_bubble=1, stall=0.
REQ-035 The bench SHALL cover MA (opcode 0000001, funct 1001) entering EX -> stall=1 and ex_hold=1 for exactly 2 cycles, then back to RUN.
REQ-036 The bench SHALL cover forwarding priority: ex_rd=mem_rd=7, both writing, ID reads rs2=7 -> fwd_b=01; with ex_rd=0 or ex_reg_write=0 -> fwd_b=10.
REQ-037 The bench SHALL cover the x0 case: ID reads rs1=0 while ex_rd=0 and ex_reg_write=1 -> fwd_a=00 and no stall.
REQ-038 The bench SHALL cover reset mid-operation: rst_n low in the first MULWAIT cycle -> all outputs 0 immediately, and RUN after release.

Source files
------------

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_if;
    // ID stage
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [3:0] id_funct;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    // ID/EX register contents
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    // EX/MEM register contents
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    // control-flow resolution in EX
    logic       ex_branch_taken;
    logic       ex_jump;
    // hazard controls back to the pipeline
    logic       stall;
    logic       idex_bubble;
    logic       flush_ifid;
    logic       ex_hold;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_valid, id_opcode, id_funct, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
        output ex_branch_taken, ex_jump,
        input  stall, idex_bubble, flush_ifid, ex_hold, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
        input  ex_branch_taken, ex_jump,
        output stall, idex_bubble, flush_ifid, ex_hold, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, redirect, multicycle-multiply hazard control and forwarding selects
module hazard_ctrl (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  bus
);

    typedef enum logic {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    localparam logic [6:0] OP_ALU_R  = 7'b0000001;
    localparam logic [6:0] OP_MULI   = 7'b0000100;
    localparam logic [3:0] FN_MUL    = 4'b0010;
    localparam logic [3:0] FN_MA     = 4'b1001;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] mul_cnt;
    logic [1:0] mul_cnt_nxt;

    logic       load_use;
    logic       redirect;
    logic       id_is_mul;

    logic       stall_c;
    logic       bubble_c;
    logic       flush_c;
    logic       hold_c;

    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    // Operand source select: the newest producer (EX/MEM) wins over MEM/WB; x0 never forwards
    // because a zero destination never matches through the rd!=0 terms.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] exrd,
        input logic       exw,
        input logic [4:0] memrd,
        input logic       memw
    );
        if (exw && (exrd != 5'd0) && (rs == exrd)) begin
            return FWD_EXMEM;
        end else if (memw && (memrd != 5'd0) && (rs == memrd)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_RF;
        end
    endfunction

    assign id_is_mul = ((bus.id_opcode == OP_ALU_R) &&
                        ((bus.id_funct == FN_MUL) || (bus.id_funct == FN_MA))) ||
                       (bus.id_opcode == OP_MULI);

    assign load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    assign redirect = bus.ex_branch_taken || bus.ex_jump;

    assign fwd_a_c = fwd_sel(bus.id_rs1, bus.ex_rd, bus.ex_reg_write, bus.mem_rd, bus.mem_reg_write);
    assign fwd_b_c = fwd_sel(bus.id_rs2, bus.ex_rd, bus.ex_reg_write, bus.mem_rd, bus.mem_reg_write);

    // State register and multiply wait counter; reset aborts any multiply wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mul_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    // Next-state and hazard controls: redirect beats load-use, multiply wait masks both
    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        hold_c      = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (bus.id_valid && id_is_mul) begin
                    // multiply enters EX this edge and occupies it for two more cycles
                    state_nxt   = MULWAIT;
                    mul_cnt_nxt = 2'd2;
                end
            end
            MULWAIT: begin
                stall_c     = 1'b1;
                hold_c      = 1'b1;
                mul_cnt_nxt = mul_cnt - 2'd1;
                if (mul_cnt <= 2'd1) begin
                    state_nxt   = RUN;
                    mul_cnt_nxt = 2'd0;
                end
            end
            default: begin
                state_nxt   = RUN;
                mul_cnt_nxt = 2'd0;
            end
        endcase
    end

    // Forwarding selects travel with the instruction into EX: cleared by a bubble, frozen by a hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (bubble_c) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (!(stall_c || hold_c)) begin
            fwd_a_q <= fwd_a_c;
            fwd_b_q <= fwd_b_c;
        end
    end

    // Controls are forced low for the whole time reset is held, independent of the clock
    assign bus.stall       = rst_n && stall_c;
    assign bus.idex_bubble = rst_n && bubble_c;
    assign bus.flush_ifid  = rst_n && flush_c;
    assign bus.ex_hold     = rst_n && hold_c;
    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed and random stimulus
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_if hif();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    typedef struct {
        logic       rst;      // 1 = reset asserted this cycle
        logic       id_valid;
        logic [6:0] op;
        logic [3:0] funct;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] ex_rd;
        logic       ex_w;
        logic       ex_mr;
        logic [4:0] mem_rd;
        logic       mem_w;
        logic       br;
        logic       jmp;
    } stim_t;

    typedef struct {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic       hold;
        logic [1:0] fa;
        logic [1:0] fb;
        string      tag;
    } exp_t;

    exp_t  exp_q[$];
    stim_t st;
    string cur_tag;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: cycles of multiply wait still owed, and the selects now in EX
    int         m_mul_left = 0;
    logic [1:0] m_fa = 2'b00;
    logic [1:0] m_fb = 2'b00;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    function automatic logic is_mul(input logic [6:0] op, input logic [3:0] f);
        return (op == 7'b0000001 && (f == 4'b0010 || f == 4'b1001)) || op == 7'b0000100;
    endfunction

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
        if (rs == 5'd0)                     return 2'b00;
        if (s.ex_w && s.ex_rd == rs)        return 2'b01;
        if (s.mem_w && s.mem_rd == rs)      return 2'b10;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, id_valid: 1'b0, op: 7'd0, funct: 4'd0, rs1: 5'd0, rs2: 5'd0,
              u1: 1'b0, u2: 1'b0, ex_rd: 5'd0, ex_w: 1'b0, ex_mr: 1'b0,
              mem_rd: 5'd0, mem_w: 1'b0, br: 1'b0, jmp: 1'b0};
        return s;
    endfunction

    // Apply one cycle of stimulus and queue what the DUT should show during that cycle
    task automatic step();
        exp_t e;
        logic lu;
        logic redir;
        @(negedge clk);
        rst_n                = ~st.rst;
        hif.id_valid         = st.id_valid;
        hif.id_opcode        = st.op;
        hif.id_funct         = st.funct;
        hif.id_rs1           = st.rs1;
        hif.id_rs2           = st.rs2;
        hif.id_use_rs1       = st.u1;
        hif.id_use_rs2       = st.u2;
        hif.ex_rd            = st.ex_rd;
        hif.ex_reg_write     = st.ex_w;
        hif.ex_mem_read      = st.ex_mr;
        hif.mem_rd           = st.mem_rd;
        hif.mem_reg_write    = st.mem_w;
        hif.ex_branch_taken  = st.br;
        hif.ex_jump          = st.jmp;

        if (st.rst) begin
            m_mul_left = 0;
            m_fa       = 2'b00;
            m_fb       = 2'b00;
        end

        lu    = st.id_valid && st.ex_mr && st.ex_rd != 0 &&
                ((st.u1 && st.rs1 == st.ex_rd) || (st.u2 && st.rs2 == st.ex_rd));
        redir = st.br || st.jmp;

        e = '{stall: 1'b0, bubble: 1'b0, flush: 1'b0, hold: 1'b0, fa: m_fa, fb: m_fb, tag: cur_tag};
        if (!st.rst) begin
            if (m_mul_left > 0) begin
                e.stall = 1'b1;
                e.hold  = 1'b1;
            end else if (redir) begin
                e.flush  = 1'b1;
                e.bubble = 1'b1;
            end else if (lu) begin
                e.stall  = 1'b1;
                e.bubble = 1'b1;
            end
        end
        exp_q.push_back(e);

        // advance the model to what the coming rising edge produces
        if (!st.rst) begin
            if (e.bubble) begin
                m_fa = 2'b00;
                m_fb = 2'b00;
            end else if (!(e.stall || e.hold)) begin
                m_fa = ref_fwd(st, st.rs1);
                m_fb = ref_fwd(st, st.rs2);
            end
            if (m_mul_left > 0)
                m_mul_left = m_mul_left - 1;
            else if (st.id_valid && is_mul(st.op, st.funct) && !e.bubble && !e.stall)
                m_mul_left = 2;
        end
    endtask

    task automatic check(input string tag, input string field, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    // Monitor: mid-cycle, after inputs settle, compare DUT outputs with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, "stall",       int'(hif.stall),       int'(e.stall));
                check(e.tag, "idex_bubble", int'(hif.idex_bubble), int'(e.bubble));
                check(e.tag, "flush_ifid",  int'(hif.flush_ifid),  int'(e.flush));
                check(e.tag, "ex_hold",     int'(hif.ex_hold),     int'(e.hold));
                check(e.tag, "fwd_a",       int'(hif.fwd_a),       int'(e.fa));
                check(e.tag, "fwd_b",       int'(hif.fwd_b),       int'(e.fb));
            end
        end
    end

    // Stimulus: directed scenarios followed by constrained-random traffic
    initial begin
        int guard;
        rst_n = 1'b0;
        hif.id_valid = 0; hif.id_opcode = 0; hif.id_funct = 0; hif.id_rs1 = 0; hif.id_rs2 = 0;
        hif.id_use_rs1 = 0; hif.id_use_rs2 = 0; hif.ex_rd = 0; hif.ex_reg_write = 0;
        hif.ex_mem_read = 0; hif.mem_rd = 0; hif.mem_reg_write = 0;
        hif.ex_branch_taken = 0; hif.ex_jump = 0;

        cur_tag = "reset";
        st = idle(); st.rst = 1'b1;
        repeat (2) step();
        st = idle();
        step();

        // load-use on x5 then the ADD enters EX with the load now in EX/MEM
        cur_tag = "load_use";
        st = idle();
        st.id_valid = 1; st.op = OP_ADD; st.rs1 = 5; st.rs2 = 2; st.u1 = 1; st.u2 = 1;
        st.ex_rd = 5; st.ex_w = 1; st.ex_mr = 1;
        step();
        cur_tag = "load_use_fwd";
        st.ex_rd = 0; st.ex_w = 0; st.ex_mr = 0; st.mem_rd = 5; st.mem_w = 1;
        step();
        st = idle();
        step();

        // taken branch together with a load-use hazard
        cur_tag = "redirect_vs_load_use";
        st = idle();
        st.id_valid = 1; st.op = OP_ADD; st.rs1 = 5; st.u1 = 1;
        st.ex_rd = 5; st.ex_w = 1; st.ex_mr = 1; st.br = 1;
        step();
        cur_tag = "jump";
        st = idle(); st.jmp = 1;
        step();

        // MA occupies EX for three cycles
        cur_tag = "ma_wait";
        st = idle();
        st.id_valid = 1; st.op = 7'b0000001; st.funct = 4'b1001; st.rs1 = 3; st.u1 = 1;
        step();
        st = idle(); st.id_valid = 1; st.op = OP_ADD; st.rs1 = 1; st.u1 = 1;
        st.br = 1;
        repeat (3) step();
        st = idle();
        step();

        // forwarding priority on rs2
        cur_tag = "fwd_prio";
        st = idle();
        st.id_valid = 1; st.op = OP_ADD; st.rs2 = 7; st.u2 = 1;
        st.ex_rd = 7; st.ex_w = 1; st.mem_rd = 7; st.mem_w = 1;
        step();
        cur_tag = "fwd_prio_exw0";
        st.ex_w = 0;
        step();
        cur_tag = "fwd_prio_exrd0";
        st.ex_w = 1; st.ex_rd = 0;
        step();
        st = idle();
        step();

        // x0 source never forwards and never stalls
        cur_tag = "x0";
        st = idle();
        st.id_valid = 1; st.op = OP_ADD; st.rs1 = 0; st.u1 = 1;
        st.ex_rd = 0; st.ex_w = 1; st.ex_mr = 1; st.mem_rd = 0; st.mem_w = 1;
        step();
        st = idle();
        step();

        // reset during the first multiply wait cycle
        cur_tag = "reset_mulwait";
        st = idle();
        st.id_valid = 1; st.op = 7'b0000100; st.rs1 = 4; st.u1 = 1; st.ex_rd = 4; st.ex_w = 1;
        step();
        st = idle(); st.rst = 1;
        step();
        st = idle(); st.id_valid = 1; st.op = OP_ADD;
        repeat (2) step();

        // random traffic with a small register space to provoke hazards
        cur_tag = "random";
        for (int i = 0; i < 600; i++) begin
            int sel;
            st = idle();
            st.rst      = ($urandom_range(0, 99) < 2);
            st.id_valid = ($urandom_range(0, 99) < 80);
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: begin st.op = 7'b0000001; st.funct = 4'b0010; end
                1: begin st.op = 7'b0000001; st.funct = 4'b1001; end
                2: begin st.op = 7'b0000100; st.funct = 4'($urandom); end
                3: begin st.op = 7'b0000001; st.funct = 4'($urandom); end
                default: begin st.op = OP_ADD; st.funct = 4'($urandom); end
            endcase
            st.rs1    = 5'($urandom_range(0, 3));
            st.rs2    = 5'($urandom_range(0, 3));
            st.u1     = 1'($urandom);
            st.u2     = 1'($urandom);
            st.ex_rd  = 5'($urandom_range(0, 3));
            st.ex_w   = 1'($urandom);
            st.ex_mr  = ($urandom_range(0, 99) < 30);
            st.mem_rd = 5'($urandom_range(0, 3));
            st.mem_w  = 1'($urandom);
            st.br     = ($urandom_range(0, 99) < 10);
            st.jmp    = ($urandom_range(0, 99) < 5);
            step();
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #5;
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
